// File: rtl/cv32e40px_core_v_xif_pkg.sv
// Shared CV-X-IF types: coprocessor result record and the per-slot
// bookkeeping used by the offload result reorder buffer.
package cv32e40px_core_v_xif_pkg;

   localparam int unsigned XIF_ID_WIDTH  = 4;
   localparam int unsigned XIF_RFW_WIDTH = 32;
   localparam int unsigned XIF_XLEN      = 32;
   localparam int unsigned XIF_NWE       = XIF_RFW_WIDTH / XIF_XLEN;

   typedef struct packed {
      logic [XIF_ID_WIDTH-1:0]  id;
      logic [XIF_RFW_WIDTH-1:0] data;
      logic [4:0]               rd;
      logic [XIF_NWE-1:0]       we;
      logic                     exc;
      logic [5:0]               exccode;
      logic                     err;
      logic                     dbg;
   } x_result_t;

   typedef enum logic [1:0] {
      FREE      = 2'b00,
      ISSUED    = 2'b01,
      COMMITTED = 2'b10,
      KILLED    = 2'b11
   } x_rob_state_e;

   // Result payload mirrors the x_result_t field widths; the slot index stands in for the ID.
   typedef struct packed {
      x_rob_state_e             state;
      logic                     wb;
      logic                     res_valid;
      logic [XIF_RFW_WIDTH-1:0] data;
      logic [4:0]               rd;
      logic [XIF_NWE-1:0]       we;
      logic                     exc;
      logic [5:0]               exccode;
   } x_rob_entry_t;

endpackage

// File: rtl/cv32e40px_xif_result_rob.sv
// CV-X-IF offload tracker and result reorder buffer: hands out IDs, tracks
// commit/kill, and writes coprocessor results back to the core in issue order.
module cv32e40px_xif_result_rob
   import cv32e40px_core_v_xif_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH  = 4,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned X_RFW_WIDTH = 32,
   localparam int unsigned IDX_W      = $clog2(DEPTH),
   localparam int unsigned NWE        = X_RFW_WIDTH / 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alloc_valid_i,
   input  logic                   alloc_wb_i,
   output logic                   alloc_ready_o,
   output logic [X_ID_WIDTH-1:0]  alloc_id_o,
   input  logic                   commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]  commit_id_i,
   input  logic                   commit_kill_i,
   input  logic                   result_valid_i,
   output logic                   result_ready_o,
   input  logic [X_ID_WIDTH-1:0]  result_id_i,
   input  logic [X_RFW_WIDTH-1:0] result_data_i,
   input  logic [4:0]             result_rd_i,
   input  logic [NWE-1:0]         result_we_i,
   input  logic                   result_exc_i,
   input  logic [5:0]             result_exccode_i,
   output logic                   wb_valid_o,
   input  logic                   wb_ready_i,
   output logic [X_ID_WIDTH-1:0]  wb_id_o,
   output logic [X_RFW_WIDTH-1:0] wb_data_o,
   output logic [4:0]             wb_rd_o,
   output logic [NWE-1:0]         wb_we_o,
   output logic                   wb_exc_o,
   output logic [5:0]             wb_exccode_o,
   output logic [IDX_W:0]         outstanding_o,
   output logic                   protocol_err_o
);

   x_rob_entry_t           slot_q [DEPTH];
   x_rob_entry_t           slot_d [DEPTH];
   logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
   logic [IDX_W:0]         count_q, count_d;
   logic                   err_q, err_d;

   logic                   wb_valid_q, wb_valid_d;
   logic [IDX_W-1:0]       wb_idx_q, wb_idx_d;
   logic [X_RFW_WIDTH-1:0] wb_data_q, wb_data_d;
   logic [4:0]             wb_rd_q, wb_rd_d;
   logic [NWE-1:0]         wb_we_q, wb_we_d;
   logic                   wb_exc_q, wb_exc_d;
   logic [5:0]             wb_exccode_q, wb_exccode_d;

   logic [IDX_W-1:0]       commit_idx, result_idx, head_nxt;
   x_rob_entry_t           head_e, nxt_e, commit_e, result_e;
   logic                   alloc_fire, commit_ok, result_ok, retire_fire;

   assign commit_idx = commit_id_i[IDX_W-1:0];
   assign result_idx = result_id_i[IDX_W-1:0];
   assign head_nxt   = head_q + 1'b1;
   assign head_e     = slot_q[head_q];
   assign nxt_e      = slot_q[head_nxt];
   assign commit_e   = slot_q[commit_idx];
   assign result_e   = slot_q[result_idx];

   assign alloc_fire = alloc_valid_i && !count_q[IDX_W];
   assign commit_ok  = commit_valid_i && ((commit_id_i >> IDX_W) == '0) &&
                       (commit_e.state == ISSUED);
   assign result_ok  = result_valid_i && ((result_id_i >> IDX_W) == '0) &&
                       ((result_e.state == ISSUED) || (result_e.state == COMMITTED)) &&
                       result_e.wb && !result_e.res_valid;

   always_comb begin
      slot_d       = slot_q;
      head_d       = head_q;
      tail_d       = tail_q;
      err_d        = err_q || (commit_valid_i && !commit_ok) || (result_valid_i && !result_ok);
      retire_fire  = 1'b0;
      wb_valid_d   = wb_valid_q;
      wb_idx_d     = wb_idx_q;
      wb_data_d    = wb_data_q;
      wb_rd_d      = wb_rd_q;
      wb_we_d      = wb_we_q;
      wb_exc_d     = wb_exc_q;
      wb_exccode_d = wb_exccode_q;

      if (wb_valid_q) begin
         if (wb_ready_i) begin
            retire_fire = 1'b1;
            wb_valid_d  = 1'b0;
            // Look one slot ahead so consecutive ready heads stream one per cycle.
            if (nxt_e.state == COMMITTED && nxt_e.wb && nxt_e.res_valid) begin
               wb_valid_d   = 1'b1;
               wb_idx_d     = head_nxt;
               wb_data_d    = nxt_e.data;
               wb_rd_d      = nxt_e.rd;
               wb_we_d      = nxt_e.we;
               wb_exc_d     = nxt_e.exc;
               wb_exccode_d = nxt_e.exccode;
            end
         end
      end else if (count_q != '0) begin
         case (head_e.state)
            KILLED: retire_fire = 1'b1;
            COMMITTED: begin
               if (!head_e.wb) begin
                  retire_fire = 1'b1;
               end else if (head_e.res_valid) begin
                  wb_valid_d   = 1'b1;
                  wb_idx_d     = head_q;
                  wb_data_d    = head_e.data;
                  wb_rd_d      = head_e.rd;
                  wb_we_d      = head_e.we;
                  wb_exc_d     = head_e.exc;
                  wb_exccode_d = head_e.exccode;
               end else if (result_ok && (result_idx == head_q)) begin
                  // Result landing on a committed head goes straight to the writeback register.
                  wb_valid_d   = 1'b1;
                  wb_idx_d     = head_q;
                  wb_data_d    = result_data_i;
                  wb_rd_d      = result_rd_i;
                  wb_we_d      = result_we_i;
                  wb_exc_d     = result_exc_i;
                  wb_exccode_d = result_exccode_i;
               end
            end
            default: ;
         endcase
      end

      if (retire_fire) begin
         slot_d[head_q].state     = FREE;
         slot_d[head_q].res_valid = 1'b0;
         head_d                   = head_nxt;
      end
      if (alloc_fire) begin
         slot_d[tail_q].state     = ISSUED;
         slot_d[tail_q].wb        = alloc_wb_i;
         slot_d[tail_q].res_valid = 1'b0;
         tail_d                   = tail_q + 1'b1;
      end
      if (commit_ok) begin
         slot_d[commit_idx].state = commit_kill_i ? KILLED : COMMITTED;
      end
      if (result_ok) begin
         slot_d[result_idx].res_valid = 1'b1;
         slot_d[result_idx].data      = result_data_i;
         slot_d[result_idx].rd        = result_rd_i;
         slot_d[result_idx].we        = result_we_i;
         slot_d[result_idx].exc       = result_exc_i;
         slot_d[result_idx].exccode   = result_exccode_i;
      end

      count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(retire_fire);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         wb_valid_q   <= 1'b0;
         wb_idx_q     <= '0;
         wb_data_q    <= '0;
         wb_rd_q      <= '0;
         wb_we_q      <= '0;
         wb_exc_q     <= 1'b0;
         wb_exccode_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
         end
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         err_q        <= err_d;
         wb_valid_q   <= wb_valid_d;
         wb_idx_q     <= wb_idx_d;
         wb_data_q    <= wb_data_d;
         wb_rd_q      <= wb_rd_d;
         wb_we_q      <= wb_we_d;
         wb_exc_q     <= wb_exc_d;
         wb_exccode_q <= wb_exccode_d;
      end
   end

   assign alloc_ready_o  = !count_q[IDX_W];
   assign alloc_id_o     = X_ID_WIDTH'(tail_q);
   assign result_ready_o = 1'b1;
   assign wb_valid_o     = wb_valid_q;
   assign wb_id_o        = X_ID_WIDTH'(wb_idx_q);
   assign wb_data_o      = wb_data_q;
   assign wb_rd_o        = wb_rd_q;
   assign wb_we_o        = wb_we_q;
   assign wb_exc_o       = wb_exc_q;
   assign wb_exccode_o   = wb_exccode_q;
   assign outstanding_o  = count_q;
   assign protocol_err_o = err_q;

endmodule

// File: tb/tb_cv32e40px_xif_result_rob.sv
// Directed bench for the CV-X-IF result reorder buffer: ordering, full/wrap,
// kill, backpressure, protocol errors and mid-operation reset.
module tb_cv32e40px_xif_result_rob;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        alloc_valid_i, alloc_wb_i, alloc_ready_o;
   logic [3:0]  alloc_id_o;
   logic        commit_valid_i, commit_kill_i;
   logic [3:0]  commit_id_i;
   logic        result_valid_i, result_ready_o;
   logic [3:0]  result_id_i;
   logic [31:0] result_data_i;
   logic [4:0]  result_rd_i;
   logic [0:0]  result_we_i;
   logic        result_exc_i;
   logic [5:0]  result_exccode_i;
   logic        wb_valid_o, wb_ready_i;
   logic [3:0]  wb_id_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   logic [0:0]  wb_we_o;
   logic        wb_exc_o;
   logic [5:0]  wb_exccode_o;
   logic [3:0]  outstanding_o;
   logic        protocol_err_o;

   int checks = 0;
   int errors = 0;

   logic [3:0]  mon_id   [$];
   logic [31:0] mon_data [$];
   logic [4:0]  mon_rd   [$];

   always #5 clk = ~clk;

   cv32e40px_xif_result_rob #(
      .X_ID_WIDTH (4),
      .DEPTH      (8),
      .X_RFW_WIDTH(32)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alloc_valid_i   (alloc_valid_i),
      .alloc_wb_i      (alloc_wb_i),
      .alloc_ready_o   (alloc_ready_o),
      .alloc_id_o      (alloc_id_o),
      .commit_valid_i  (commit_valid_i),
      .commit_id_i     (commit_id_i),
      .commit_kill_i   (commit_kill_i),
      .result_valid_i  (result_valid_i),
      .result_ready_o  (result_ready_o),
      .result_id_i     (result_id_i),
      .result_data_i   (result_data_i),
      .result_rd_i     (result_rd_i),
      .result_we_i     (result_we_i),
      .result_exc_i    (result_exc_i),
      .result_exccode_i(result_exccode_i),
      .wb_valid_o      (wb_valid_o),
      .wb_ready_i      (wb_ready_i),
      .wb_id_o         (wb_id_o),
      .wb_data_o       (wb_data_o),
      .wb_rd_o         (wb_rd_o),
      .wb_we_o         (wb_we_o),
      .wb_exc_o        (wb_exc_o),
      .wb_exccode_o    (wb_exccode_o),
      .outstanding_o   (outstanding_o),
      .protocol_err_o  (protocol_err_o)
   );

   // Inputs change at posedge+1, so the negedge view is exactly what the next edge captures.
   always @(negedge clk) begin
      if (rst_n && wb_valid_o && wb_ready_i) begin
         mon_id.push_back(wb_id_o);
         mon_data.push_back(wb_data_o);
         mon_rd.push_back(wb_rd_o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      alloc_valid_i    = 1'b0;
      alloc_wb_i       = 1'b0;
      commit_valid_i   = 1'b0;
      commit_id_i      = '0;
      commit_kill_i    = 1'b0;
      result_valid_i   = 1'b0;
      result_id_i      = '0;
      result_data_i    = '0;
      result_rd_i      = '0;
      result_we_i      = '0;
      result_exc_i     = 1'b0;
      result_exccode_i = '0;
   endtask

   task automatic clear_mon();
      mon_id.delete();
      mon_data.delete();
      mon_rd.delete();
   endtask

   task automatic apply_reset();
      clear_inputs();
      wb_ready_i = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_mon();
      step();
   endtask

   task automatic do_alloc(input logic wb);
      alloc_valid_i = 1'b1;
      alloc_wb_i    = wb;
      step();
      alloc_valid_i = 1'b0;
      alloc_wb_i    = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] id, input logic kill);
      commit_valid_i = 1'b1;
      commit_id_i    = id;
      commit_kill_i  = kill;
      step();
      commit_valid_i = 1'b0;
      commit_kill_i  = 1'b0;
   endtask

   task automatic do_result(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd);
      result_valid_i = 1'b1;
      result_id_i    = id;
      result_data_i  = data;
      result_rd_i    = rd;
      result_we_i    = 1'b1;
      step();
      result_valid_i = 1'b0;
      result_we_i    = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (outstanding_o !== 4'd0 && n < 40) begin
         step();
         n++;
      end
      checks++;
      if (outstanding_o !== 4'd0) begin
         errors++;
         $display("FAIL %s drain: outstanding=%0d required 0", name, outstanding_o);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({alloc_ready_o, result_ready_o, wb_valid_o, protocol_err_o} !== 4'b1100) begin
         errors++;
         $display("FAIL reset flags: got %b required 1100",
                  {alloc_ready_o, result_ready_o, wb_valid_o, protocol_err_o});
      end
      checks++;
      if (outstanding_o !== 4'd0 || alloc_id_o !== 4'd0) begin
         errors++;
         $display("FAIL reset counters: outstanding=%0d alloc_id=%0d required 0/0", outstanding_o, alloc_id_o);
      end
      checks++;
      if (wb_data_o !== 32'd0 || wb_id_o !== 4'd0 || wb_rd_o !== 5'd0) begin
         errors++;
         $display("FAIL reset payload: data=%h id=%0d rd=%0d required 0", wb_data_o, wb_id_o, wb_rd_o);
      end
   endtask

   task automatic test_inorder();
      logic [3:0] order [3];
      order[0] = 4'd2; order[1] = 4'd0; order[2] = 4'd1;
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (alloc_id_o !== 4'(i)) begin
            errors++;
            $display("FAIL inorder alloc_id: got %0d required %0d", alloc_id_o, i);
         end
         do_alloc(1'b1);
      end
      for (int i = 0; i < 3; i++) do_result(order[i], 32'hA000_0000 + 32'(order[i]), 5'(order[i] + 1));
      for (int i = 0; i < 3; i++) do_commit(4'(i), 1'b0);
      wait_empty("inorder");
      checks++;
      if (mon_id.size() != 3) begin
         errors++;
         $display("FAIL inorder wb count: got %0d required 3", mon_id.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (mon_id[i] !== 4'(i) || mon_data[i] !== 32'hA000_0000 + 32'(i) || mon_rd[i] !== 5'(i + 1)) begin
               errors++;
               $display("FAIL inorder wb[%0d]: id=%0d data=%h rd=%0d required id=%0d data=%h rd=%0d",
                        i, mon_id[i], mon_data[i], mon_rd[i], i, 32'hA000_0000 + 32'(i), i + 1);
            end
         end
      end
   endtask

   task automatic test_full_wrap();
      apply_reset();
      for (int i = 0; i < 8; i++) do_alloc(1'b0);
      checks++;
      if (alloc_ready_o !== 1'b0 || outstanding_o !== 4'd8) begin
         errors++;
         $display("FAIL full: ready=%b outstanding=%0d required 0/8", alloc_ready_o, outstanding_o);
      end
      do_alloc(1'b0);
      checks++;
      if (outstanding_o !== 4'd8 || protocol_err_o !== 1'b0) begin
         errors++;
         $display("FAIL full alloc ignored: outstanding=%0d err=%b required 8/0", outstanding_o, protocol_err_o);
      end
      do_commit(4'd0, 1'b0);
      checks++;
      if (alloc_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL full no bypass: ready=%b required 0", alloc_ready_o);
      end
      step();
      checks++;
      if (alloc_ready_o !== 1'b1 || alloc_id_o !== 4'd0 || outstanding_o !== 4'd7) begin
         errors++;
         $display("FAIL wrap: ready=%b id=%0d outstanding=%0d required 1/0/7", alloc_ready_o, alloc_id_o, outstanding_o);
      end
      do_commit(4'd1, 1'b0);
      do_alloc(1'b0);
      checks++;
      if (outstanding_o !== 4'd7 || alloc_id_o !== 4'd1) begin
         errors++;
         $display("FAIL alloc+retire: outstanding=%0d id=%0d required 7/1", outstanding_o, alloc_id_o);
      end
   endtask

   task automatic test_kill();
      apply_reset();
      do_alloc(1'b1);
      do_alloc(1'b1);
      do_commit(4'd0, 1'b1);
      do_commit(4'd1, 1'b0);
      do_result(4'd1, 32'hDEADBEEF, 5'd5);
      checks++;
      if (wb_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL kill latency: wb_valid=%b required 1", wb_valid_o);
      end
      wait_empty("kill");
      checks++;
      if (mon_id.size() != 1) begin
         errors++;
         $display("FAIL kill wb count: got %0d required 1", mon_id.size());
      end else begin
         checks++;
         if (mon_id[0] !== 4'd1 || mon_rd[0] !== 5'd5 || mon_data[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL kill wb: id=%0d rd=%0d data=%h required 1/5/deadbeef", mon_id[0], mon_rd[0], mon_data[0]);
         end
      end
      checks++;
      if (protocol_err_o !== 1'b0) begin
         errors++;
         $display("FAIL kill err: got %b required 0", protocol_err_o);
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      wb_ready_i = 1'b0;
      do_alloc(1'b1);
      do_commit(4'd0, 1'b0);
      result_exc_i     = 1'b1;
      result_exccode_i = 6'h0B;
      do_result(4'd0, 32'hCAFEF00D, 5'd7);
      result_exc_i     = 1'b0;
      result_exccode_i = '0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hCAFEF00D || wb_rd_o !== 5'd7 || wb_id_o !== 4'd0 ||
             wb_exc_o !== 1'b1 || wb_exccode_o !== 6'h0B || wb_we_o !== 1'b1 || outstanding_o !== 4'd1) begin
            errors++;
            $display("FAIL hold[%0d]: v=%b data=%h rd=%0d id=%0d exc=%b code=%h out=%0d required 1/cafef00d/7/0/1/0b/1",
                     i, wb_valid_o, wb_data_o, wb_rd_o, wb_id_o, wb_exc_o, wb_exccode_o, outstanding_o);
         end
         step();
      end
      wb_ready_i = 1'b1;
      step();
      checks++;
      if (wb_valid_o !== 1'b0 || outstanding_o !== 4'd0 || mon_id.size() != 1) begin
         errors++;
         $display("FAIL release: v=%b outstanding=%0d wbs=%0d required 0/0/1", wb_valid_o, outstanding_o, mon_id.size());
      end
   endtask

   task automatic test_protocol_err();
      apply_reset();
      for (int i = 0; i < 3; i++) do_alloc(1'b1);
      do_result(4'd3, 32'h1234_5678, 5'd9);
      checks++;
      if (protocol_err_o !== 1'b1 || outstanding_o !== 4'd3 || wb_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL err result: err=%b outstanding=%0d v=%b required 1/3/0", protocol_err_o, outstanding_o, wb_valid_o);
      end
      do_commit(4'd3, 1'b0);
      repeat (3) step();
      checks++;
      if (protocol_err_o !== 1'b1 || outstanding_o !== 4'd3 || alloc_id_o !== 4'd3 || mon_id.size() != 0) begin
         errors++;
         $display("FAIL err sticky: err=%b outstanding=%0d id=%0d wbs=%0d required 1/3/3/0",
                  protocol_err_o, outstanding_o, alloc_id_o, mon_id.size());
      end
   endtask

   task automatic test_dup_result();
      apply_reset();
      do_alloc(1'b1);
      do_result(4'd0, 32'h0000_AAAA, 5'd3);
      checks++;
      if (protocol_err_o !== 1'b0) begin
         errors++;
         $display("FAIL dup first: err=%b required 0", protocol_err_o);
      end
      do_result(4'd0, 32'h0000_BBBB, 5'd4);
      checks++;
      if (protocol_err_o !== 1'b1) begin
         errors++;
         $display("FAIL dup second: err=%b required 1", protocol_err_o);
      end
      do_commit(4'd0, 1'b0);
      wait_empty("dup");
      checks++;
      if (mon_id.size() != 1 || mon_data[0] !== 32'h0000_AAAA || mon_rd[0] !== 5'd3) begin
         errors++;
         $display("FAIL dup wb: count=%0d data=%h rd=%0d required 1/0000aaaa/3",
                  mon_id.size(), mon_data[0], mon_rd[0]);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      wb_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) do_alloc(1'b1);
      do_commit(4'd0, 1'b0);
      do_result(4'd0, 32'h5555_0000, 5'd2);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({alloc_ready_o, result_ready_o, wb_valid_o, protocol_err_o} !== 4'b1100 ||
          outstanding_o !== 4'd0 || alloc_id_o !== 4'd0) begin
         errors++;
         $display("FAIL async reset: flags=%b outstanding=%0d id=%0d required 1100/0/0",
                  {alloc_ready_o, result_ready_o, wb_valid_o, protocol_err_o}, outstanding_o, alloc_id_o);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      wb_ready_i = 1'b1;
      clear_mon();
      step();
      checks++;
      if (alloc_id_o !== 4'd0) begin
         errors++;
         $display("FAIL post-reset alloc_id: got %0d required 0", alloc_id_o);
      end
      do_alloc(1'b1);
      repeat (4) step();
      checks++;
      if (mon_id.size() != 0 || outstanding_o !== 4'd1) begin
         errors++;
         $display("FAIL post-reset: wbs=%0d outstanding=%0d required 0/1", mon_id.size(), outstanding_o);
      end
   endtask

   initial begin
      clear_inputs();
      wb_ready_i = 1'b1;
      test_reset();
      test_inorder();
      test_full_wrap();
      test_kill();
      test_backpressure();
      test_protocol_err();
      test_dup_result();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
